// File: rtl/banked_ram_arb.sv
// banked_ram_arb
//   Banked synchronous RAM shared by a read/write CPU port and a read-only
//   video port. The top BANK_BITS address bits select a bank. Each bank is a
//   single-port synchronous RAM. Accesses to different banks complete in the
//   same cycle. When both ports hit the same bank, video wins, but the CPU is
//   forced through after MAX_WAIT consecutive losses (MAX_WAIT=0 gives strict
//   video priority).
//
// Ports
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   cpu_req/we/ad/di      CPU request; hold stable until cpu_ack
//   cpu_do, cpu_ack       CPU read data (valid with ack on reads), 1-cycle ack
//   vid_req/ad            video read request; hold stable until vid_ack
//   vid_do, vid_ack       video read data, 1-cycle ack
//   conflict_cnt          saturating count of same-bank conflict edges
module banked_ram_arb #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13,
  parameter int BANK_BITS = 2,
  parameter int MAX_WAIT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [DATA_W-1:0] cpu_di,
  output logic [DATA_W-1:0] cpu_do,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_ad,
  output logic [DATA_W-1:0] vid_do,
  output logic              vid_ack,
  output logic [15:0]       conflict_cnt
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int LOCAL_W   = ADDR_W - BANK_BITS;
  localparam int DEPTH     = 1 << LOCAL_W;

  logic [BANK_BITS-1:0] cpu_bank, vid_bank;
  logic [LOCAL_W-1:0]   cpu_local, vid_local;

  assign cpu_bank  = cpu_ad[ADDR_W-1 -: BANK_BITS];
  assign vid_bank  = vid_ad[ADDR_W-1 -: BANK_BITS];
  assign cpu_local = cpu_ad[LOCAL_W-1:0];
  assign vid_local = vid_ad[LOCAL_W-1:0];

  // ---------------------------------------------------------------------------
  // Arbitration
  // A port's req is always a live request: while ack=0 it is the pending
  // access, while ack=1 it is already the next access. So req alone qualifies.
  // ---------------------------------------------------------------------------
  logic [3:0] wait_cnt;
  logic       conflict;
  logic       force_cpu;
  logic       cpu_grant;
  logic       vid_grant;

  // NOTE: every always_comb output gets a value on every path (here by plain
  // unconditional assignment) so no latch is inferred.
  always_comb begin
    conflict  = cpu_req && vid_req && (cpu_bank == vid_bank);
    // MAX_WAIT=0 means the guard never fires: strict video priority.
    force_cpu = (MAX_WAIT != 0) && (wait_cnt == 4'(MAX_WAIT));
    cpu_grant = cpu_req && (!conflict || force_cpu);
    vid_grant = vid_req && (!conflict || !force_cpu);
  end

  // ---------------------------------------------------------------------------
  // Banks: each bank sees at most one granted access per edge, so a simple
  // single-port RAM with a port mux suffices.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] bank_q [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;
    logic              sel_cpu, sel_vid, en, we;
    logic [LOCAL_W-1:0] addr;

    always_comb begin
      sel_cpu = cpu_grant && (cpu_bank == BANK_BITS'(b));
      sel_vid = vid_grant && (vid_bank == BANK_BITS'(b));
      // Gating by !reset keeps a request pending at reset from writing.
      en      = (sel_cpu || sel_vid) && !reset;
      we      = sel_cpu && cpu_we && !reset;
      addr    = sel_cpu ? cpu_local : vid_local;
    end

    // NOTE: RAM arrays and their read registers have no reset; clearing a
    // memory would prevent block-RAM inference and its contents must survive
    // reset anyway.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we) mem[addr] <= cpu_di;
        else    q         <= mem[addr];
      end
    end

    assign bank_q[b] = q;
  end

  // ---------------------------------------------------------------------------
  // Acks, read-data steering and counters
  // *_do shows the bank read register during a read-ack cycle and otherwise
  // a holding copy of itself, so it only changes on that port's read acks even
  // if the other port reads the same bank later. Both sources are flops.
  // ---------------------------------------------------------------------------
  logic                 cpu_rd, vid_rd;
  logic [BANK_BITS-1:0] cpu_sel, vid_sel;
  logic [DATA_W-1:0]    cpu_hold, vid_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ack      <= 1'b0;
      vid_ack      <= 1'b0;
      cpu_rd       <= 1'b0;
      vid_rd       <= 1'b0;
      cpu_sel      <= '0;
      vid_sel      <= '0;
      cpu_hold     <= '0;
      vid_hold     <= '0;
      wait_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      cpu_ack  <= cpu_grant;
      vid_ack  <= vid_grant;
      cpu_rd   <= cpu_grant && !cpu_we;
      vid_rd   <= vid_grant;
      cpu_hold <= cpu_do;
      vid_hold <= vid_do;
      if (cpu_grant) cpu_sel <= cpu_bank;
      if (vid_grant) vid_sel <= vid_bank;

      if (cpu_grant || !cpu_req)
        wait_cnt <= '0;
      else if (conflict && wait_cnt != 4'hF)
        wait_cnt <= wait_cnt + 4'd1;

      if (conflict && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_comb begin
    cpu_do = cpu_rd ? bank_q[cpu_sel] : cpu_hold;
    vid_do = vid_rd ? bank_q[vid_sel] : vid_hold;
  end

endmodule

// File: tb/tb_banked_ram_arb.sv
// tb_banked_ram_arb
//   Table-driven bench for banked_ram_arb (default parameters: 8-bit data,
//   13-bit address, 4 banks, MAX_WAIT=3). Each table record drives one edge
//   and names the acks expected in the following cycle; read data comes from a
//   reference memory through per-port expectation queues. The same-bank
//   conflict timing is exercised by a hand-written bounded sequence.
module tb_banked_ram_arb;

  localparam int DW = 8;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_ad;
  logic [DW-1:0] cpu_di, cpu_do;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_ad;
  logic [DW-1:0] vid_do;
  logic          vid_ack;
  logic [15:0]   conflict_cnt;

  banked_ram_arb #(.DATA_W(DW), .ADDR_W(AW), .BANK_BITS(2), .MAX_WAIT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_ad       (cpu_ad),
    .cpu_di       (cpu_di),
    .cpu_do       (cpu_do),
    .cpu_ack      (cpu_ack),
    .vid_req      (vid_req),
    .vid_ad       (vid_ad),
    .vid_do       (vid_do),
    .vid_ack      (vid_ack),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_ad;
    logic [DW-1:0] c_di;
    logic          v_req;
    logic [AW-1:0] v_ad;
    logic          e_cack;
    logic          e_vack;
  } vec_t;

  typedef struct {
    logic          wr;
    logic          known;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          cpu_q[$];
  exp_t          vid_q[$];
  logic [DW-1:0] ref_mem [int];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] cpu_last = '0, vid_last = '0;
  logic          cpu_known = 1'b0, vid_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic c_req, input logic c_we,
                              input logic [AW-1:0] c_ad, input logic [DW-1:0] c_di,
                              input logic v_req, input logic [AW-1:0] v_ad,
                              input logic e_cack, input logic e_vack);
    vec_t v;
    v.rst = rst; v.c_req = c_req; v.c_we = c_we; v.c_ad = c_ad; v.c_di = c_di;
    v.v_req = v_req; v.v_ad = v_ad; v.e_cack = e_cack; v.e_vack = e_vack;
    return v;
  endfunction

  // Entered at a falling edge: drive, let one rising edge pass, then check.
  task automatic run_vec(input vec_t v);
    exp_t e;
    reset   = v.rst;
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_ad = v.c_ad; cpu_di = v.c_di;
    vid_req = v.v_req; vid_ad = v.v_ad;
    if (!v.rst) begin
      if (v.e_vack) begin
        e.wr    = 1'b0;
        e.known = ref_mem.exists(int'(v.v_ad));
        e.data  = e.known ? ref_mem[int'(v.v_ad)] : '0;
        vid_q.push_back(e);
      end
      if (v.e_cack) begin
        e.wr = v.c_we;
        if (v.c_we) begin
          e.known = 1'b1;
          e.data  = '0;
          ref_mem[int'(v.c_ad)] = v.c_di;
        end else begin
          e.known = ref_mem.exists(int'(v.c_ad));
          e.data  = e.known ? ref_mem[int'(v.c_ad)] : '0;
        end
        cpu_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (v.rst) begin
      cpu_q.delete(); vid_q.delete();
      cpu_last = '0; vid_last = '0; cpu_known = 1'b1; vid_known = 1'b1;
      check("reset_conflict_cnt", 32'(conflict_cnt), 0);
    end
    check("cpu_ack", 32'(cpu_ack), 32'(v.e_cack));
    check("vid_ack", 32'(vid_ack), 32'(v.e_vack));

    if (cpu_ack && cpu_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL cpu_unexpected_ack: got ack 1, expected 0 (t=%0t)", $time);
    end else if (cpu_ack) begin
      e = cpu_q.pop_front();
      if (!e.wr) begin cpu_last = e.data; cpu_known = e.known; end
      if (cpu_known) check("cpu_do", 32'(cpu_do), 32'(cpu_last));
    end else if (cpu_known) begin
      check("cpu_do_hold", 32'(cpu_do), 32'(cpu_last));
    end

    if (vid_ack && vid_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL vid_unexpected_ack: got ack 1, expected 0 (t=%0t)", $time);
    end else if (vid_ack) begin
      e = vid_q.pop_front();
      vid_last = e.data; vid_known = e.known;
      if (vid_known) check("vid_do", 32'(vid_do), 32'(vid_last));
    end else if (vid_known) begin
      check("vid_do_hold", 32'(vid_do), 32'(vid_last));
    end
  endtask

  // CPU read of bank 1 against continuous video reads of bank 1: video wins
  // three edges, the CPU is forced through on the fourth, then video resumes.
  task automatic conflict_run();
    int   n     = 0;
    int   vacks = 0;
    logic got   = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ad = 13'h0801; cpu_di = '0;
    vid_req = 1'b1; vid_ad = 13'h0800;
    while (!got && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (cpu_ack) begin
        got = 1'b1;
        check("conf_vid_denied", 32'(vid_ack), 0);
        check("conf_cpu_do", 32'(cpu_do), 32'h22);
      end else if (vid_ack) begin
        vacks++;
        check("conf_vid_do", 32'(vid_do), 32'h11);
      end
    end
    check("conf_cpu_latency", 32'(n), 4);
    check("conf_vid_acks", 32'(vacks), 3);
    cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("conf_vid_resume", 32'(vid_ack), 1);
    check("conf_cpu_ack_pulse", 32'(cpu_ack), 0);
    vid_req = 1'b0; vid_ad = '0;
    @(posedge clk);
    @(negedge clk);
    check("conf_vid_idle", 32'(vid_ack), 0);
    cpu_last = 8'h22; cpu_known = 1'b1;
    vid_last = 8'h11; vid_known = 1'b1;
  endtask

  // Requester hold rule: a request not acked on the next cycle must be
  // presented again unchanged. Pending requests are dropped by reset.
  logic          pc_req = 1'b0, pc_we = 1'b0, pv_req = 1'b0, p_rst = 1'b1;
  logic [AW-1:0] pc_ad = '0, pv_ad = '0;
  logic [DW-1:0] pc_di = '0;

  always @(posedge clk) begin
    if (pc_req && !p_rst && !cpu_ack) begin
      checks++;
      assert (cpu_req && cpu_we == pc_we && cpu_ad == pc_ad && (!pc_we || cpu_di == pc_di))
      else begin
        errors++;
        $display("FAIL cpu_hold_rule: got ad 0x%0h, expected 0x%0h (t=%0t)", cpu_ad, pc_ad, $time);
      end
    end
    if (pv_req && !p_rst && !vid_ack) begin
      checks++;
      assert (vid_req && vid_ad == pv_ad)
      else begin
        errors++;
        $display("FAIL vid_hold_rule: got ad 0x%0h, expected 0x%0h (t=%0t)", vid_ad, pv_ad, $time);
      end
    end
    pc_req <= cpu_req; pc_we <= cpu_we; pc_ad <= cpu_ad; pc_di <= cpu_di;
    pv_req <= vid_req; pv_ad <= vid_ad; p_rst <= reset;
  end

  vec_t p_basic[$];
  vec_t p_conf[$];
  vec_t p_stream[$];
  vec_t p_rst_mid[$];

  initial begin
    // Reset with both requests up, release, basic access, parallel banks,
    // then preload bank 1 and idle so the wait counter starts from zero.
    p_basic.push_back(mk(1, 1, 1, 13'h0123, 8'hA5, 1, 13'h1000, 0, 0));
    p_basic.push_back(mk(1, 1, 1, 13'h0123, 8'hA5, 1, 13'h1000, 0, 0));
    p_basic.push_back(mk(0, 1, 1, 13'h0123, 8'hA5, 1, 13'h1000, 1, 1));
    p_basic.push_back(mk(0, 1, 0, 13'h0123, 8'h00, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 1, 1, 13'h1923, 8'h5A, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 0, 0));
    p_basic.push_back(mk(0, 1, 0, 13'h1923, 8'h00, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 1, 0, 13'h0123, 8'h00, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 1, 1, 13'h1000, 8'h77, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 1, 0, 13'h0123, 8'h00, 1, 13'h1000, 1, 1));
    p_basic.push_back(mk(0, 1, 1, 13'h0800, 8'h11, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 1, 1, 13'h0801, 8'h22, 0, 13'h0000, 1, 0));
    p_basic.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 0, 0));

    // Same-bank conflict, MAX_WAIT=3: video, video, video, CPU, video.
    for (int i = 0; i < 3; i++)
      p_conf.push_back(mk(0, 1, 0, 13'h0801, 8'h00, 1, 13'h0800, 0, 1));
    p_conf.push_back(mk(0, 1, 0, 13'h0801, 8'h00, 1, 13'h0800, 1, 0));
    p_conf.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 1, 13'h0800, 0, 1));
    p_conf.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 0, 0));

    // CPU streaming through banks 0..3 with req held high.
    p_stream.push_back(mk(0, 1, 0, 13'h0123, 8'h00, 0, 13'h0000, 1, 0));
    p_stream.push_back(mk(0, 1, 0, 13'h0801, 8'h00, 0, 13'h0000, 1, 0));
    p_stream.push_back(mk(0, 1, 0, 13'h1000, 8'h00, 0, 13'h0000, 1, 0));
    p_stream.push_back(mk(0, 1, 0, 13'h1923, 8'h00, 0, 13'h0000, 1, 0));
    p_stream.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 0, 0));

    // Reset lands on the grant edge of a 0x3C write over 0x11.
    p_rst_mid.push_back(mk(0, 1, 1, 13'h0456, 8'h11, 0, 13'h0000, 1, 0));
    p_rst_mid.push_back(mk(1, 1, 1, 13'h0456, 8'h3C, 0, 13'h0000, 0, 0));
    p_rst_mid.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 0, 0));
    p_rst_mid.push_back(mk(0, 1, 0, 13'h0456, 8'h00, 0, 13'h0000, 1, 0));
    p_rst_mid.push_back(mk(0, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 0, 0));

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_ad = '0; cpu_di = '0;
    vid_req = 1'b0; vid_ad = '0;
    @(negedge clk);

    foreach (p_basic[i]) run_vec(p_basic[i]);
    check("parallel_conflict_cnt", 32'(conflict_cnt), 0);

    foreach (p_conf[i]) run_vec(p_conf[i]);
    check("conflict_cnt_after_4", 32'(conflict_cnt), 4);

    conflict_run();
    check("conflict_cnt_after_8", 32'(conflict_cnt), 8);

    foreach (p_stream[i]) run_vec(p_stream[i]);
    foreach (p_rst_mid[i]) run_vec(p_rst_mid[i]);
    check("final_conflict_cnt", 32'(conflict_cnt), 0);

    check("cpu_queue_drained", 32'(cpu_q.size()), 0);
    check("vid_queue_drained", 32'(vid_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
